// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial word transmitter.
// No logic of its own; consumed by serial_word_tx and lfsr8.
// No flow control here.
package serial_word_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAD  = 2'd1,
    ST_WORD = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form: stages 7,5,4,3 feed back.
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  // Default seed; any nonzero value keeps the register out of the lock-up state.
  localparam logic [7:0] LFSR_SEED_DEF = 8'hE1;

  // One LFSR step: shift towards the MSB, feedback enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/serial_word_tx_lfsr8.sv
// 8-bit Fibonacci LFSR that supplies pseudo-random pad bits.
// Latency: new state one edge after en.
// No backpressure; holds its state whenever en is low.
module lfsr8
  import serial_word_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  // Step once per enabled edge; reset returns to the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Serial transmitter: optional pad run then a stored word, MSB first, one bit per bit_tick.
// Latency: start at edge k, first bit_valid after edge k+1 (tick high); done one cycle after last strobe.
// No backpressure: bits leave on bit_tick; start/set_word while busy are dropped, abort returns to idle.
module serial_word_tx
  import serial_word_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned PAD_CW    = 5,
  parameter logic        PAD_BIT   = 1'b0,
  parameter logic [7:0]  LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_word,
  input  logic [WORD_W-1:0] word,
  input  logic [PAD_CW-1:0] pad_len,
  input  logic              pad_mode,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_tick,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  // idx must be able to hold WORD_W itself: that value marks "last bit already sent".
  localparam int unsigned IDX_W = $clog2(WORD_W + 1);

  tx_state_t         state, state_nxt;
  logic [WORD_W-1:0] word_reg, word_reg_nxt;
  logic [WORD_W-1:0] frame_word, frame_word_nxt;   // shifts left, MSB is the next bit out
  logic [PAD_CW-1:0] pad_cnt, pad_cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              frame_mode, frame_mode_nxt;
  logic              bit_out_nxt, bit_valid_nxt;
  logic              lfsr_en;
  logic [7:0]        lfsr_q;
  logic              lfsr_low_unused;

  // Pad source; steps only when a random pad bit is actually emitted, never reseeded between frames.
  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .state (lfsr_q)
  );

  // Only the MSB is emitted; the low bits matter solely for the feedback inside lfsr8.
  assign lfsr_low_unused = ^lfsr_q[6:0];

  // Next-state and next-output decode; abort outranks every state except IDLE.
  always_comb begin
    state_nxt      = state;
    word_reg_nxt   = word_reg;
    frame_word_nxt = frame_word;
    pad_cnt_nxt    = pad_cnt;
    idx_nxt        = idx;
    frame_mode_nxt = frame_mode;
    bit_out_nxt    = bit_out;
    bit_valid_nxt  = 1'b0;
    lfsr_en        = 1'b0;

    if (abort && (state != ST_IDLE)) begin
      state_nxt   = ST_IDLE;
      pad_cnt_nxt = '0;
      idx_nxt     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (set_word) begin
            word_reg_nxt = word;
          end
          if (start) begin
            // A same-cycle set_word is both stored and sent.
            frame_word_nxt = set_word ? word : word_reg;
            pad_cnt_nxt    = pad_len;
            frame_mode_nxt = pad_mode;
            idx_nxt        = '0;
            state_nxt      = (pad_len != '0) ? ST_PAD : ST_WORD;
          end
        end

        ST_PAD: begin
          if (bit_tick) begin
            bit_out_nxt   = frame_mode ? lfsr_q[7] : PAD_BIT;
            bit_valid_nxt = 1'b1;
            lfsr_en       = frame_mode;
            pad_cnt_nxt   = pad_cnt - PAD_CW'(1);
            if (pad_cnt == PAD_CW'(1)) begin
              state_nxt = ST_WORD;
            end
          end
        end

        ST_WORD: begin
          if (idx == IDX_W'(WORD_W)) begin
            // Last bit is on the wire this cycle; DONE follows regardless of tick.
            state_nxt = ST_DONE;
          end else if (bit_tick) begin
            bit_out_nxt    = frame_word[WORD_W-1];
            bit_valid_nxt  = 1'b1;
            frame_word_nxt = {frame_word[WORD_W-2:0], 1'b0};
            idx_nxt        = idx + IDX_W'(1);
          end
        end

        ST_DONE: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears the stored word as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_reg   <= '0;
      frame_word <= '0;
      pad_cnt    <= '0;
      idx        <= '0;
      frame_mode <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_reg   <= word_reg_nxt;
      frame_word <= frame_word_nxt;
      pad_cnt    <= pad_cnt_nxt;
      idx        <= idx_nxt;
      frame_mode <= frame_mode_nxt;
      bit_out    <= bit_out_nxt;
      bit_valid  <= bit_valid_nxt;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed frames plus randomized frames with junk commands and aborts,
// checked every cycle against a queue-based model of the bit stream, plus literal frame checks.
`timescale 1ns/1ps
module tb_serial_word_tx;

  localparam logic PAD_BIT_EXP = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_word = 1'b0;
  logic [7:0] word = '0;
  logic [4:0] pad_len = '0;
  logic       pad_mode = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       bit_tick;
  logic       bit_out, bit_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_per = 1;   // 0 = random tick, N = tick every Nth cycle

  always #5 clk = ~clk;

  serial_word_tx dut (
    .clk       (clk),
    .rst       (rst),
    .set_word  (set_word),
    .word      (word),
    .pad_len   (pad_len),
    .pad_mode  (pad_mode),
    .start     (start),
    .abort     (abort),
    .bit_tick  (bit_tick),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Polynomial x^8+x^6+x^5+x^4+1: new bit = XOR of the stages for exponents 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[8-1] ^ s[6-1] ^ s[5-1] ^ s[4-1];
    return {s[6:0], fb};
  endfunction

  logic [7:0] m_word_reg;
  logic [7:0] m_lfsr;
  logic [7:0] m_fw;
  int         m_q[$];    // pending bits: 0/1 literal, 2 = take next LFSR bit
  int         m_b;
  int         m_phase;   // 0 idle, 1 sending, 2 last bit on wire, 3 done pulse
  logic       e_bit_out, e_bit_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word_reg  = '0;
      m_lfsr      = 8'hE1;
      m_q.delete();
      m_phase     = 0;
      e_bit_out   = 1'b0;
      e_bit_valid = 1'b0;
    end else begin
      e_bit_valid = 1'b0;
      if (m_phase == 0) begin
        if (set_word) m_word_reg = word;
        if (start) begin
          m_fw = m_word_reg;
          m_q.delete();
          for (int i = 0; i < int'(pad_len); i++) m_q.push_back(pad_mode ? 2 : int'(PAD_BIT_EXP));
          for (int i = 7; i >= 0; i--) m_q.push_back(int'(m_fw[i]));
          m_phase = 1;
        end
      end else if (abort) begin
        m_q.delete();
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (bit_tick) begin
          m_b = m_q.pop_front();
          if (m_b == 2) begin
            e_bit_out = m_lfsr[7];
            m_lfsr    = lfsr_step(m_lfsr);
          end else begin
            e_bit_out = (m_b != 0);
          end
          e_bit_valid = 1'b1;
          if (m_q.size() == 0) m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("bit_valid", bit_valid, e_bit_valid);
    chk("bit_out",   bit_out,   e_bit_out);
    chk("busy",      busy,      m_phase != 0);
    chk("done",      done,      m_phase == 3);
  end

  // ---------------- monitors ----------------
  int cap[$];
  int cap_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bit_valid) begin
      cap.push_back(int'(bit_out));
      cap_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] cap_val();
    logic [31:0] v = '0;
    foreach (cap[i]) v = {v[30:0], (cap[i] != 0)};
    return v;
  endfunction

  // Tick generator.
  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_per == 0) bit_tick = 1'($urandom_range(0, 1));
      else               bit_tick = ((cyc % tick_per) == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] w, input logic sw, input logic [4:0] pl, input logic pm);
    @(negedge clk);
    word = w; set_word = sw; pad_len = pl; pad_mode = pm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; set_word = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic clear_cap();
    cap.delete();
    cap_cyc.delete();
  endtask

  int bad, n0, found;
  logic [7:0] sr;
  logic [7:0] rw;
  logic       rsw, rpm;
  logic [4:0] rpl;
  int         abort_at, len;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {bit_out, bit_valid, busy, done}, 4'b0000);

    // 1: A5, no pad, tick every cycle; latency and done timing.
    tick_per = 1;
    clear_cap(); n0 = done_cnt;
    send(8'hA5, 1'b1, 5'd0, 1'b0);
    chk("t1_busy_after_start", busy, 1'b1);
    chk("t1_no_bit_yet", bit_valid, 1'b0);
    @(negedge clk);
    chk("t1_first_strobe", bit_valid, 1'b1);
    wait_idle("t1");
    chk("t1_count", cap.size(), 8);
    chk("t1_bits", cap_val(), 32'hA5);
    chk("t1_consecutive", cap_cyc[cap_cyc.size()-1] - cap_cyc[0], 7);
    chk("t1_done_once", done_cnt - n0, 1);
    chk("t1_done_after_last", done_cyc, cap_cyc[cap_cyc.size()-1] + 1);

    // 2: 3C with 3 constant pad bits.
    clear_cap();
    send(8'h3C, 1'b1, 5'd3, 1'b0);
    wait_idle("t2");
    chk("t2_count", cap.size(), 11);
    chk("t2_bits", cap_val(), 32'h03C);

    // 3: 81 with tick every 4th cycle.
    tick_per = 4;
    clear_cap(); n0 = done_cnt;
    send(8'h81, 1'b1, 5'd0, 1'b0);
    wait_idle("t3");
    chk("t3_bits", cap_val(), 32'h81);
    bad = 0;
    for (int i = 1; i < cap_cyc.size(); i++) if (cap_cyc[i] - cap_cyc[i-1] != 4) bad++;
    chk("t3_spacing", bad, 0);
    chk("t3_done_once", done_cnt - n0, 1);

    // 4: commands while busy are dropped; same-cycle set_word+start sends the new word.
    tick_per = 1;
    clear_cap();
    send(8'hA5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    word = 8'hFF; set_word = 1'b1; start = 1'b1;
    @(negedge clk);
    set_word = 1'b0; start = 1'b0;
    wait_idle("t4a");
    chk("t4_frame_kept", cap_val(), 32'hA5);
    clear_cap();
    send(8'h00, 1'b0, 5'd0, 1'b0);
    wait_idle("t4b");
    chk("t4_word_reg_kept", cap_val(), 32'hA5);
    clear_cap();
    send(8'h0F, 1'b1, 5'd0, 1'b0);
    wait_idle("t4c");
    chk("t4_same_cycle", cap_val(), 32'h0F);

    // 5: abort after the third strobe.
    clear_cap(); n0 = done_cnt;
    send(8'hA5, 1'b1, 5'd0, 1'b0);
    bad = 0;
    while (cap.size() < 3 && bad < 50) begin
      @(negedge clk); #1;
      bad++;
    end
    chk("t5_reach_third", cap.size(), 3);
    abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_outputs", {bit_valid, busy}, 2'b00);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt - n0, 0);
    clear_cap();
    send(8'h00, 1'b0, 5'd0, 1'b0);
    wait_idle("t5");
    chk("t5_resend", cap_val(), 32'hA5);
    chk("t5_resend_count", cap.size(), 8);

    // 6: async reset mid-frame clears outputs at once and the stored word.
    n0 = done_cnt;
    send(8'hA5, 1'b1, 5'd4, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_async_clear", {bit_out, bit_valid, busy, done}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_no_done", done_cnt - n0, 0);
    clear_cap();
    send(8'hFF, 1'b0, 5'd0, 1'b0);
    wait_idle("t6a");
    chk("t6_word_cleared", cap_val(), 32'h00);

    // LFSR pad from the seed: E1 yields 1,1,1,0,0 for the first five pad bits.
    clear_cap();
    send(8'h5A, 1'b1, 5'd5, 1'b1);
    wait_idle("t6b");
    chk("lfsr_pad_bits", cap_val(), 32'h1C5A);

    // Loopback detector: A5 after 4 constant pad bits.
    clear_cap();
    send(8'hA5, 1'b1, 5'd4, 1'b0);
    wait_idle("t6c");
    sr = '0; found = 0;
    foreach (cap[i]) begin
      sr = {sr[6:0], (cap[i] != 0)};
      if (i >= 7 && sr == 8'hA5) found = 1;
    end
    chk("loopback_found", found, 1);

    // Maximum pad length with random pad.
    clear_cap();
    send(8'hC3, 1'b1, 5'd31, 1'b1);
    wait_idle("maxpad");
    chk("maxpad_count", cap.size(), 39);
    chk("maxpad_word", cap_val() & 32'hFF, 32'hC3);

    // Randomized frames with junk commands and occasional aborts.
    for (int it = 0; it < 40; it++) begin
      tick_per = $urandom_range(0, 3);
      rw  = 8'($urandom);
      rsw = 1'($urandom_range(0, 1));
      rpm = 1'($urandom_range(0, 1));
      rpl = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      len = 200;
      send(rw, rsw, rpl, rpm);
      for (int c = 0; c < len && busy; c++) begin
        set_word = 1'b0; start = 1'b0; abort = 1'b0;
        if ($urandom_range(0, 9) == 0) begin
          word = 8'($urandom); set_word = 1'($urandom_range(0, 1)); start = 1'b1;
        end
        if (c == abort_at) abort = 1'b1;
        @(negedge clk);
      end
      set_word = 1'b0; start = 1'b0; abort = 1'b0;
      wait_idle("rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected completion before 3ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
